alu_arbiter: RTL

- Shares one combinational 4-bit ALU (operands A/B, 2-bit OP, result R, carry flag CF) between two requesters.
- Round-robin arbitration; valid/ready request handshake per requester.
- Operands registered onto the ALU ports; result/CF captured into a response register held until the winning requester accepts it.
- Sits between two datapath masters (e.g. sequencer and debug port) and the single ALU instance; ALU is external, wired to the alu_* ports.

---
 rtl/alu_arbiter_if.sv | 42 ++++
 rtl/alu_arbiter.sv | 87 ++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// Bundle of requester, ALU and response signals for the two-master ALU arbiter.
// The slave modport is the arbiter's view. The master modport is the view of the requesters and the ALU.
interface alu_arbiter_if #(parameter int WIDTH = 4);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [1:0]       req0_op;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [1:0]       req1_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [1:0]       alu_op;
  logic [WIDTH-1:0] alu_r;
  logic             alu_cf;
  logic             rsp0_valid;
  logic             rsp1_valid;
  logic             rsp0_ready;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp_r;
  logic             rsp_cf;
  logic             busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  alu_r, alu_cf, rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, alu_a, alu_b, alu_op,
    output rsp0_valid, rsp1_valid, rsp_r, rsp_cf, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output alu_r, alu_cf, rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, alu_a, alu_b, alu_op,
    input  rsp0_valid, rsp1_valid, rsp_r, rsp_cf, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one external combinational ALU between two requesters.
// It registers the operands onto the ALU and holds each result until its owner accepts it.
module alu_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus
);
  // state | meaning
  // IDLE  | combinational grant, waiting for a request handshake
  // EXEC  | operands registered on the ALU, result settling
  // RESP  | result held for the owner until its rsp_ready
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t state, state_nxt;
  logic   owner;
  logic   last_grant;
  logic   grant0, grant1;
  logic   accept;
  logic   rsp_accept;

  always_comb begin
    state_nxt      = state;
    grant0         = 1'b0;
    grant1         = 1'b0;
    accept         = 1'b0;
    rsp_accept     = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.busy       = (state != IDLE);
    // On a tie, the requester that was not served last wins.
    grant0 = bus.req0_valid && (!bus.req1_valid || last_grant);
    grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant);
    unique case (state)
      IDLE: begin
        bus.req0_ready = grant0;
        bus.req1_ready = grant1;
        accept         = grant0 || grant1;
        if (accept) state_nxt = EXEC;
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp_accept = owner ? bus.rsp1_ready : bus.rsp0_ready;
        if (rsp_accept) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
      bus.alu_op     <= '0;
      bus.rsp_r      <= '0;
      bus.rsp_cf     <= 1'b0;
      bus.rsp0_valid <= 1'b0;
      bus.rsp1_valid <= 1'b0;
      owner          <= 1'b0;
      last_grant     <= 1'b1;
    end else begin
      if (accept) begin
        owner      <= grant1;
        last_grant <= grant1;
        bus.alu_a  <= grant1 ? bus.req1_a  : bus.req0_a;
        bus.alu_b  <= grant1 ? bus.req1_b  : bus.req0_b;
        bus.alu_op <= grant1 ? bus.req1_op : bus.req0_op;
      end
      if (state == EXEC) begin
        bus.rsp_r      <= bus.alu_r;
        bus.rsp_cf     <= bus.alu_cf;
        bus.rsp0_valid <= !owner;
        bus.rsp1_valid <= owner;
      end
      if (rsp_accept) begin
        bus.rsp0_valid <= 1'b0;
        bus.rsp1_valid <= 1'b0;
      end
    end
  end
endmodule
